// File: rtl/articolor_ctrl.sv
// rtl/articolor_ctrl.sv - frame-synchronous artifact colorizer control
// Optional auto detection (luma hit counter + hysteresis FSM) built when ARTICOLOR_AUTO_EN is defined.
module articolor_ctrl #(
  parameter int THRESH = 2048,
  parameter int HYST   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [1:0]  mode,
  input  logic        swap_req,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        hbl_in,
  input  logic        vbl_in,
  input  logic        vs_in,
  output logic        enable,
  output logic        colorset,
  output logic        colorswap,
  output logic        detected,
  output logic [15:0] hits_last
);

  logic vs_prev;
  logic fb;
  logic auto_on;

  assign fb = ce_pix & vs_in & ~vs_prev;

  // Previous vsync resets high so the first cycle out of reset never looks like a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev <= 1'b1;
    end else if (ce_pix) begin
      vs_prev <= vs_in;
    end
  end

`ifdef ARTICOLOR_AUTO_EN
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;
  localparam logic [3:0] HYST_L  = 4'(HYST);
  localparam bit         HYST_GT1 = (HYST > 1);

  logic [9:0]  y_sum;
  logic [7:0]  y_in;
  logic [7:0]  y_d0;
  logic [7:0]  y_d1;
  logic        hit;
  logic [15:0] hit_cnt;
  logic        above;
  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [3:0]  run;
  logic [3:0]  run_nx;
  logic        detected_nx;

  assign y_sum = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
  assign y_in  = 8'(y_sum >> 2);

  // A hit is a strict local extremum at the previous pixel, ignoring near-black noise.
  assign hit = ~hbl_in & ~vbl_in & (y_d0 >= 8'd10) &
               (((y_d0 > y_in) & (y_d0 > y_d1)) | ((y_d0 < y_in) & (y_d0 < y_d1)));

  assign above = ({1'b0, hit_cnt} >= 17'(THRESH));

  always_comb begin
    state_nx = state;
    run_nx   = run;
    case (state)
      ST_OFF: begin
        if (above) begin
          run_nx   = 4'd1;
          state_nx = HYST_GT1 ? ST_RISE : ST_ON;
        end
      end
      ST_RISE: begin
        if (above) begin
          run_nx = run + 4'd1;
          if (run + 4'd1 == HYST_L) state_nx = ST_ON;
        end else begin
          state_nx = ST_OFF;
        end
      end
      ST_ON: begin
        if (!above) begin
          run_nx   = 4'd1;
          state_nx = HYST_GT1 ? ST_FALL : ST_OFF;
        end
      end
      default: begin
        if (!above) begin
          run_nx = run + 4'd1;
          if (run + 4'd1 == HYST_L) state_nx = ST_OFF;
        end else begin
          state_nx = ST_ON;
        end
      end
    endcase
  end

  assign detected_nx = (state_nx == ST_ON) | (state_nx == ST_FALL);
  // The enable latched at a frame boundary sees the decision taken in that same boundary.
  assign auto_on     = (mode == 2'd3) & detected_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_d0      <= 8'd0;
      y_d1      <= 8'd0;
      hit_cnt   <= 16'd0;
      hits_last <= 16'd0;
      state     <= ST_OFF;
      run       <= 4'd0;
      detected  <= 1'b0;
    end else if (ce_pix) begin
      y_d0 <= y_in;
      y_d1 <= y_d0;
      if (fb) begin
        hits_last <= hit_cnt;
        hit_cnt   <= 16'd0;
        state     <= state_nx;
        run       <= run_nx;
        detected  <= detected_nx;
      end else if (hit && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_pix;

  assign unused_pix = ^{r_in, g_in, b_in, hbl_in, vbl_in, 16'(THRESH), 4'(HYST)};
  assign detected   = 1'b0;
  assign hits_last  = 16'd0;
  assign auto_on    = (mode == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= 1'b0;
      colorset  <= 1'b1;
      colorswap <= 1'b0;
    end else if (fb) begin
      enable    <= (mode == 2'd1) | (mode == 2'd2) | auto_on;
      colorset  <= (mode != 2'd2);
      colorswap <= swap_req;
    end
  end

endmodule

// File: doc/articolor_ctrl.md
# articolor_ctrl

Frame-synchronous controller for the artifact colorizer stage. Takes the OSD artifact-colour settings, and optionally measures hi-res alternating-luma content per frame. Drives the colorizer's `enable`, `colorset` and `colorswap` controls, changing them only at frame boundaries so that a setting never changes mid-picture. Sits beside the colorizer on the same pixel clock, and taps the same RGB/blanking stream that feeds the colorizer.

## Interface
Parameters:
- `THRESH`, default 2048: per-frame pattern-hit count at or above which a frame counts as "artifact-rich".
- `HYST`, default 4: number of consecutive agreeing frames needed to switch the auto decision (range 1..15).

Ports:
- `clk` — in, 1: system clock.
- `reset` — in, 1: synchronous, active-high reset.
- `ce_pix` — in, 1: pixel clock enable. All state advances only when it is 1.
- `mode` — in, 2: 0 = off, 1 = set 1 forced on, 2 = set 2 forced on, 3 = auto (set 1 when detected).
- `swap_req` — in, 1: OSD phase-swap request, level.
- `r_in`, `g_in`, `b_in` — in, 8 each: pixel stream.
- `hbl_in`, `vbl_in`, `vs_in` — in, 1 each: blanking and vertical sync.
- `enable` — out, 1: colorizer enable.
- `colorset` — out, 1: 1 = set 1, 0 = set 2.
- `colorswap` — out, 1: colorizer phase swap.
- `detected` — out, 1: current auto decision (status for OSD).
- `hits_last` — out, 16: pattern-hit count of the previous frame.

## Operation
- **Frame boundary (FB):** a `ce_pix` cycle where `vs_in` = 1 and the registered previous `vs_in` = 0.
- **Luma:** `y = (r_in + 2*g_in + b_in) >> 2`. Compute in 10 bits, keep 8. Keep `y_d0` and `y_d1`, advanced on every `ce_pix`.
- **Hit:** a `ce_pix` cycle with `hbl_in` = 0, `vbl_in` = 0, `y_d0` >= 10, and `y_d0` a strict local extremum, i.e. (`y_d0` > `y_in` and `y_d0` > `y_d1`) or (`y_d0` < `y_in` and `y_d0` < `y_d1`).
- **Hit counter:** 16-bit, saturates at 0xFFFF.
- **At FB:**
  - `hits_last` <= counter.
  - Counter <= 0. A hit in the same cycle is discarded.
  - `above` = (counter >= `THRESH`).
- **Auto FSM** (advances only at FB; run counter is 4 bits):
  - OFF: if `above`, run <= 1. Go to RISE if `HYST` > 1, else go directly to ON.
  - RISE: if `above`, run++; when run reaches `HYST` go to ON. If not `above`, go to OFF.
  - ON: if not `above`, run <= 1. Go to FALL if `HYST` > 1, else go directly to OFF.
  - FALL: if not `above`, run++; when run reaches `HYST` go to OFF. If `above`, go to ON.
  - `detected` = 1 in ON and FALL.
- **Control latch (at FB only):**
  - `enable` <= (`mode` = 1) | (`mode` = 2) | (`mode` = 3 & `detected`_next).
  - `colorset` <= (`mode` != 2).
  - `colorswap` <= `swap_req`.
- Changes to `mode` or `swap_req` between FBs have no effect on outputs until the next FB.
- The FSM and counter run regardless of `mode`, so switching into auto takes effect with no settling delay.

## Timing
- **Reset values:**
  - `enable` = 0, `colorset` = 1, `colorswap` = 0, `detected` = 0, `hits_last` = 0.
  - Hit counter = 0, FSM = OFF, run = 0, `y_d0` = `y_d1` = 0.
  - Previous `vs_in` = 1, so no FB is seen on the first cycle out of reset.
- **Latency:** outputs are registered and change one `clk` after the FB `ce_pix` cycle.
- **`ce_pix` = 0:** all registers hold.
- **Reset mid-frame:** everything returns to reset values. The first FB after reset uses a partial-frame count.
- **Simultaneous FB and auto transition:** `enable` uses the post-transition decision in the same FB.

## Configuration
- `ARTICOLOR_AUTO_EN` defined: the luma/hit logic and the auto FSM are built as described.
- `ARTICOLOR_AUTO_EN` undefined:
  - The hit logic and FSM are removed.
  - `detected` = 0 and `hits_last` = 0 constantly.
  - `mode` = 3 behaves exactly as `mode` = 1.

## Test plan
- **Reset:** reset, then `mode` = 1 with no `vs_in` edge → `enable` = 0. First FB → `enable` = 1, `colorset` = 1 one clk later.
- **Set 2 forced:** `mode` = 2, `swap_req` = 1, changed mid-frame → outputs unchanged until FB, then `enable` = 1, `colorset` = 0, `colorswap` = 1.
- **Auto rise:** `mode` = 3, `HYST` = 4, `THRESH` = 2048, frames of alternating 0x20/0xC0 grey (~40000 hits) → `enable` rises at the 4th FB after the first rich frame. `hits_last` = the actual count.
- **Auto hysteresis:** while ON, feed 3 flat frames then 1 rich frame → stays ON. Then 4 flat frames → `enable` = 0 at the 4th FB.
- **Saturation and blanking:** 70000 hits in one frame → `hits_last` = 0xFFFF. Extrema supplied only during `hbl_in` = 1 → `hits_last` = 0.
- **Macro off:** build without `ARTICOLOR_AUTO_EN`, `mode` = 3 → `enable` = 1 and `colorset` = 1 at first FB, `detected` = 0.
